// File: rtl/intersection_ctrl.sv
// Traffic-light phase controller: round-robin service of latched requests with a timed
// all-red clearance between green phases. Define TLC_PREEMPT_EN to add emergency preemption.
module intersection_ctrl #(
  parameter int GREEN_CYCLES = 8,
  parameter int CLEAR_CYCLES = 2,
  parameter int TIMER_W      = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic up_req,
  input  logic down_req,
  input  logic turn_req,
  input  logic ped_req,
`ifdef TLC_PREEMPT_EN
  input  logic preempt,
`endif
  output logic up_green,
  output logic down_green,
  output logic turn_green,
  output logic pedestrian_green,
  output logic all_red
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_G_UP,
    S_G_DOWN,
    S_G_TURN,
    S_G_PED
  } state_e;

  // Phase indices double as bit positions in the request/pending vectors.
  localparam logic [1:0] PH_UP   = 2'd0;
  localparam logic [1:0] PH_DOWN = 2'd1;
  localparam logic [1:0] PH_TURN = 2'd2;
  localparam logic [1:0] PH_PED  = 2'd3;

  localparam logic [TIMER_W-1:0] GREEN_LAST = TIMER_W'(GREEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(CLEAR_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         pending_q, pending_d;
  logic [1:0]         rr_last_q, rr_last_d;

  logic [3:0] req_vec;
  logic [3:0] cur_mask;
  logic [3:0] grant_mask;
  logic [1:0] arb_phase;
  logic       arb_valid;
  logic       grant;

  assign req_vec = {ped_req, turn_req, down_req, up_req};

  function automatic state_e phase_state(input logic [1:0] ph);
    case (ph)
      PH_UP:   return S_G_UP;
      PH_DOWN: return S_G_DOWN;
      PH_TURN: return S_G_TURN;
      default: return S_G_PED;
    endcase
  endfunction

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cur_mask = '0;
    case (state_q)
      S_G_UP:   cur_mask[PH_UP]   = 1'b1;
      S_G_DOWN: cur_mask[PH_DOWN] = 1'b1;
      S_G_TURN: cur_mask[PH_TURN] = 1'b1;
      S_G_PED:  cur_mask[PH_PED]  = 1'b1;
      default:  ;
    endcase
  end

  // Scan from farthest to nearest after rr_last so the nearest pending phase wins.
  always_comb begin
    arb_valid = 1'b0;
    arb_phase = rr_last_q;
    for (int i = 4; i >= 1; i--) begin
      if (pending_q[rr_last_q + 2'(i)]) begin
        arb_valid = 1'b1;
        arb_phase = rr_last_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rr_last_d = rr_last_q;
    grant     = 1'b0;

    case (state_q)
      S_IDLE: grant = arb_valid;
      S_CLEAR: begin
        if (timer_q == CLEAR_LAST) begin
          timer_d = '0;
          if (arb_valid) grant = 1'b1;
          else           state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_G_UP, S_G_DOWN, S_G_TURN, S_G_PED: begin
        // Timer saturates at the last green cycle; green holds until a rival request appears.
        if (timer_q == GREEN_LAST) begin
          if (|(pending_q & ~cur_mask)) begin
            state_d = S_CLEAR;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    if (grant) begin
      state_d   = phase_state(arb_phase);
      timer_d   = '0;
      rr_last_d = arb_phase;
    end
    grant_mask = grant ? (4'b0001 << arb_phase) : 4'b0000;

`ifdef TLC_PREEMPT_EN
    if (preempt) begin
      state_d    = S_CLEAR;
      timer_d    = '0;
      rr_last_d  = rr_last_q;
      grant_mask = 4'b0000;
    end
`endif

    pending_d = (pending_q | (req_vec & ~cur_mask)) & ~grant_mask;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      rr_last_q <= PH_PED;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Lights are registered from the next state so they change in step with state_q, glitch-free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      up_green         <= 1'b0;
      down_green       <= 1'b0;
      turn_green       <= 1'b0;
      pedestrian_green <= 1'b0;
      all_red          <= 1'b1;
    end else begin
      up_green         <= (state_d == S_G_UP);
      down_green       <= (state_d == S_G_DOWN);
      turn_green       <= (state_d == S_G_TURN) || (state_d == S_G_PED);
      pedestrian_green <= (state_d == S_G_PED);
      all_red          <= (state_d == S_IDLE) || (state_d == S_CLEAR);
    end
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Randomized and directed bench for intersection_ctrl against a phase-level reference model.
module tb_intersection_ctrl;

  localparam int GREEN = 8;
  localparam int CLEAR = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic up_req = 1'b0, down_req = 1'b0, turn_req = 1'b0, ped_req = 1'b0;
`ifdef TLC_PREEMPT_EN
  logic preempt = 1'b0;
`endif
  logic up_green, down_green, turn_green, pedestrian_green, all_red;
  logic [4:0] lights;

  int checks = 0;
  int errors = 0;

  assign lights = {up_green, down_green, turn_green, pedestrian_green, all_red};

  always #5 clock = ~clock;

  intersection_ctrl #(
    .GREEN_CYCLES(GREEN),
    .CLEAR_CYCLES(CLEAR),
    .TIMER_W     (8)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .up_req          (up_req),
    .down_req        (down_req),
    .turn_req        (turn_req),
    .ped_req         (ped_req),
`ifdef TLC_PREEMPT_EN
    .preempt         (preempt),
`endif
    .up_green        (up_green),
    .down_green      (down_green),
    .turn_green      (turn_green),
    .pedestrian_green(pedestrian_green),
    .all_red         (all_red)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which phase is lit, how many cycles it has lasted, and the request set.
  typedef enum {M_IDLE, M_CLEAR, M_GREEN} mode_e;
  mode_e    m_mode;
  int       m_phase;
  int       m_count;
  bit [3:0] m_pend;
  int       m_last;

  // Clearance tracker for the green-to-green invariant.
  logic [3:0] prev_set;
  int         reds;

  function automatic void model_reset();
    m_mode   = M_IDLE;
    m_phase  = 0;
    m_count  = 0;
    m_pend   = '0;
    m_last   = 3;
    prev_set = '0;
    reds     = 0;
  endfunction

  function automatic logic [4:0] m_lights();
    if (m_mode != M_GREEN) return 5'b00001;
    case (m_phase)
      0:       return 5'b10000;
      1:       return 5'b01000;
      2:       return 5'b00100;
      default: return 5'b00110;
    endcase
  endfunction

  function automatic void model_step(input bit [3:0] r, input bit pre);
    bit [3:0] own;
    bit [3:0] old;
    bit       go;
    int       pick;
    own  = (m_mode == M_GREEN) ? 4'(4'b0001 << m_phase) : 4'b0000;
    old  = m_pend;
    go   = 1'b0;
    pick = 0;
    m_pend = m_pend | (r & ~own);
    if (pre) begin
      m_mode  = M_CLEAR;
      m_count = 0;
      return;
    end
    case (m_mode)
      M_IDLE: go = (old != 0);
      M_GREEN: begin
        m_count++;
        if (m_count >= GREEN && (old & ~own) != 0) begin
          m_mode  = M_CLEAR;
          m_count = 0;
        end
      end
      default: begin
        m_count++;
        if (m_count >= CLEAR) begin
          if (old != 0) go = 1'b1;
          else begin
            m_mode  = M_IDLE;
            m_count = 0;
          end
        end
      end
    endcase
    if (go) begin
      for (int k = 1; k <= 4; k++) begin
        if (old[(m_last + k) % 4]) begin
          pick = (m_last + k) % 4;
          break;
        end
      end
      m_mode       = M_GREEN;
      m_phase      = pick;
      m_count      = 0;
      m_last       = pick;
      m_pend[pick] = 1'b0;
    end
  endfunction

  // Called at a falling edge: drive inputs, advance the model across one rising edge, compare.
  task automatic cycle(input bit [3:0] r, input bit pre);
    logic [3:0] gs;
    bit         one_walk;
    bit         no_cross;
    bit         pre_eff;
    up_req   = r[0];
    down_req = r[1];
    turn_req = r[2];
    ped_req  = r[3];
`ifdef TLC_PREEMPT_EN
    preempt = pre;
    pre_eff = pre;
`else
    pre_eff = 1'b0;
`endif
    model_step(r, pre_eff);
    @(posedge clock);
    @(negedge clock);
    check("lights", 32'(lights), 32'(m_lights()));
    one_walk = (int'(up_green) + int'(down_green) + int'(pedestrian_green)) <= 1;
    no_cross = !((up_green || down_green) && turn_green);
    check("inv_exclusive", 32'(one_walk && no_cross), 32'(1));
    gs = {up_green, down_green, turn_green, pedestrian_green};
    if (gs == 4'b0000) reds++;
    else begin
      if (prev_set != 4'b0000 && gs != prev_set) check("inv_clearance", 32'(reds >= CLEAR), 32'(1));
      prev_set = gs;
      reds     = 0;
    end
  endtask

  // Called at a falling edge; asserts reset mid-cycle and releases it at the next falling edge.
  task automatic async_reset();
    up_req = 1'b0; down_req = 1'b0; turn_req = 1'b0; ped_req = 1'b0;
`ifdef TLC_PREEMPT_EN
    preempt = 1'b0;
`endif
    #2 reset_n = 1'b0;
    #1 check("reset_async", 32'(lights), 32'(5'b00001));
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [4:0] exp_q[$];
    int         up_cnt;
    int         down_cnt;
    bit [3:0]   r;
    bit         pre;

    model_reset();
    @(negedge clock);
    check("reset_state", 32'(lights), 32'(5'b00001));
    reset_n = 1'b1;

    // Idle: nothing requested, all red throughout.
    for (int i = 0; i < 20; i++) cycle(4'b0000, 1'b0);

    // Pedestrian pulse: green two edges later, held while nothing else asks.
    cycle(4'b1000, 1'b0);
    check("ped_not_yet", 32'(lights), 32'(5'b00001));
    cycle(4'b0000, 1'b0);
    check("ped_green", 32'(lights), 32'(5'b00110));
    for (int i = 0; i < 15; i++) cycle(4'b0000, 1'b0);
    check("ped_hold", 32'(lights), 32'(5'b00110));

    // Up request while pedestrians hold: exactly two all-red cycles before up.
    cycle(4'b0001, 1'b0);
    check("ped_before_clear", 32'(lights), 32'(5'b00110));
    cycle(4'b0000, 1'b0);
    check("clear_1", 32'(lights), 32'(5'b00001));
    cycle(4'b0000, 1'b0);
    check("clear_2", 32'(lights), 32'(5'b00001));
    cycle(4'b0000, 1'b0);
    check("up_after_clear", 32'(lights), 32'(5'b10000));
    for (int i = 0; i < 6; i++) cycle(4'b0000, 1'b0);

    // All four requested at once: UP, DOWN, TURN, PED(+turn), 8 green each, 2 red between.
    async_reset();
    exp_q.push_back(5'b00001);
    for (int i = 0; i < GREEN; i++) exp_q.push_back(5'b10000);
    for (int i = 0; i < CLEAR; i++) exp_q.push_back(5'b00001);
    for (int i = 0; i < GREEN; i++) exp_q.push_back(5'b01000);
    for (int i = 0; i < CLEAR; i++) exp_q.push_back(5'b00001);
    for (int i = 0; i < GREEN; i++) exp_q.push_back(5'b00100);
    for (int i = 0; i < CLEAR; i++) exp_q.push_back(5'b00001);
    for (int i = 0; i < 5; i++) exp_q.push_back(5'b00110);
    foreach (exp_q[i]) begin
      cycle((i == 0) ? 4'b1111 : 4'b0000, 1'b0);
      check("all4_order", 32'(lights), 32'(exp_q[i]));
    end

    // Up held during its own green is not re-granted; a down request ends it after 8 cycles.
    async_reset();
    up_cnt   = 0;
    down_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 3)       r = 4'b0001;
      else if (i == 3) r = 4'b0011;
      else if (i == 4) r = 4'b0001;
      else             r = 4'b0000;
      cycle(r, 1'b0);
      if (up_green)   up_cnt++;
      if (down_green) down_cnt++;
    end
    check("up_run_len", 32'(up_cnt), 32'(GREEN));
    check("down_reached", 32'(down_cnt > 0), 32'(1));
    check("down_holding", 32'(lights), 32'(5'b01000));

    // Reset during G_DOWN with a turn request pending: all red at once, stays idle.
    cycle(4'b0100, 1'b0);
    async_reset();
    for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0);
    check("idle_after_reset", 32'(lights), 32'(5'b00001));

`ifdef TLC_PREEMPT_EN
    // Preempt during G_TURN with a pedestrian request pending.
    async_reset();
    cycle(4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0);
    cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, 1'b1);
      check("preempt_red", 32'(lights), 32'(5'b00001));
    end
    for (int i = 0; i < 12; i++) cycle(4'b0000, 1'b0);
    check("ped_after_preempt", 32'(lights), 32'(5'b00110));
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 9) == 0);
      pre = ($urandom_range(0, 79) == 0);
      cycle(r, pre);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
